// File: rtl/jtcps1_snd_romarb.sv
// rtl/jtcps1_snd_romarb.sv - sound ROM arbiter between Z80 program and OKI sample ports
//
// Shares one downstream read slot between the sound CPU program ROM and the
// ADPCM sample ROM. Each client has a one-entry tagged byte cache, so repeated
// reads of the same address never reach memory. The CPU has fixed priority;
// ADPCM overrides it once it has been kept waiting for MAXWAIT cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cpu_cs, cpu_addr    CPU read request and byte address
//   cpu_data, cpu_ok    cached CPU byte, valid for the current cpu_addr
//   pcm_cs, pcm_addr    ADPCM read request and byte address
//   pcm_data, pcm_ok    cached ADPCM byte, valid for the current pcm_addr
//   mem_cs, mem_addr    downstream request and byte address
//   mem_data, mem_ok    downstream read data and data-valid strobe

module jtcps1_snd_romarb #(
    parameter int                CPU_AW     = 16,
    parameter int                PCM_AW     = 18,
    parameter int                MEM_AW     = 19,
    parameter logic [MEM_AW-1:0] PCM_OFFSET = 19'h10000,
    parameter int                MAXWAIT    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cs,
    input  logic [CPU_AW-1:0] cpu_addr,
    output logic [7:0]        cpu_data,
    output logic              cpu_ok,
    input  logic              pcm_cs,
    input  logic [PCM_AW-1:0] pcm_addr,
    output logic [7:0]        pcm_data,
    output logic              pcm_ok,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_ok
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] MAXW = 4'(MAXWAIT);

    state_t            state, state_nx;
    logic              owner_pcm;
    logic [CPU_AW-1:0] cpu_tag, cpu_req;
    logic [PCM_AW-1:0] pcm_tag, pcm_req;
    logic              cpu_valid, pcm_valid;
    logic [3:0]        wait_cnt;

    logic              cpu_hit, pcm_hit;
    logic              pend_cpu, pend_pcm;
    logic              grant_cpu, grant_pcm;
    logic              capture;
    logic              pcm_busy;
    logic [MEM_AW-1:0] cpu_ext, pcm_map;

    assign cpu_hit  = cpu_valid && (cpu_tag == cpu_addr);
    assign pcm_hit  = pcm_valid && (pcm_tag == pcm_addr);
    assign cpu_ok   = cpu_cs && cpu_hit;
    assign pcm_ok   = pcm_cs && pcm_hit;
    assign pend_cpu = cpu_cs && !cpu_hit;
    assign pend_pcm = pcm_cs && !pcm_hit;

    assign cpu_ext  = {{(MEM_AW-CPU_AW){1'b0}}, cpu_addr};
    assign pcm_map  = {{(MEM_AW-PCM_AW){1'b0}}, pcm_addr} + PCM_OFFSET;

    // PCM only counts as being served while a transfer it owns is in flight.
    assign pcm_busy = (state != ST_IDLE) && owner_pcm;

    always_comb begin
        state_nx  = state;
        grant_cpu = 1'b0;
        grant_pcm = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_pcm && (!pend_cpu || wait_cnt >= MAXW)) begin
                    grant_pcm = 1'b1;
                    state_nx  = ST_ISSUE;
                end else if (pend_cpu) begin
                    grant_cpu = 1'b1;
                    state_nx  = ST_ISSUE;
                end
            end
            // mem_ok may still be high from the previous transfer, so it is
            // not trusted until the request has been seen for a full cycle.
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (mem_ok) begin
                    capture  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            owner_pcm <= 1'b0;
            mem_cs    <= 1'b0;
            mem_addr  <= '0;
            cpu_req   <= '0;
            pcm_req   <= '0;
            cpu_tag   <= '0;
            pcm_tag   <= '0;
            cpu_valid <= 1'b0;
            pcm_valid <= 1'b0;
            cpu_data  <= 8'h00;
            pcm_data  <= 8'h00;
            wait_cnt  <= 4'd0;
        end else begin
            state <= state_nx;
            if (grant_cpu) begin
                owner_pcm <= 1'b0;
                cpu_req   <= cpu_addr;
                mem_addr  <= cpu_ext;
                mem_cs    <= 1'b1;
            end
            if (grant_pcm) begin
                owner_pcm <= 1'b1;
                pcm_req   <= pcm_addr;
                mem_addr  <= pcm_map;
                mem_cs    <= 1'b1;
            end
            // The tag takes the address that was issued; the client may have
            // moved on since, in which case it simply misses and re-requests.
            if (capture) begin
                mem_cs <= 1'b0;
                if (owner_pcm) begin
                    pcm_data  <= mem_data;
                    pcm_tag   <= pcm_req;
                    pcm_valid <= 1'b1;
                end else begin
                    cpu_data  <= mem_data;
                    cpu_tag   <= cpu_req;
                    cpu_valid <= 1'b1;
                end
            end
            if (grant_pcm || !pend_pcm) begin
                wait_cnt <= 4'd0;
            end else if (!pcm_busy && wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_snd_romarb.sv
// tb/tb_jtcps1_snd_romarb.sv - self-checking bench for jtcps1_snd_romarb

module tb_jtcps1_snd_romarb;

    localparam logic [18:0] OFF     = 19'h10000;
    localparam int          MAXWAIT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        pcm_cs;
    logic [17:0] pcm_addr;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        mem_cs;
    logic [18:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ok;

    int n_cmp = 0;
    int n_err = 0;

    jtcps1_snd_romarb #(
        .CPU_AW     (16),
        .PCM_AW     (18),
        .MEM_AW     (19),
        .PCM_OFFSET (OFF),
        .MAXWAIT    (MAXWAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_cs   (cpu_cs),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_ok   (cpu_ok),
        .pcm_cs   (pcm_cs),
        .pcm_addr (pcm_addr),
        .pcm_data (pcm_data),
        .pcm_ok   (pcm_ok),
        .mem_cs   (mem_cs),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ok   (mem_ok)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        cpu_cs;
        logic [15:0] cpu_addr;
        logic        pcm_cs;
        logic [17:0] pcm_addr;
        logic        mem_ok;
        logic [7:0]  mem_data;
        logic        e_mem_cs;
        logic [18:0] e_mem_addr;
        logic        e_cpu_ok;
        logic [7:0]  e_cpu_data;
        logic        e_pcm_ok;
        logic [7:0]  e_pcm_data;
    } vec_t;

    vec_t tbl[14];

    // Downstream memory contents: a fixed function of the byte address.
    function automatic logic [7:0] fmem(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {a[18:16], 5'h15};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cpu_cs   = 1'b0;
        cpu_addr = 16'h0;
        pcm_cs   = 1'b0;
        pcm_addr = 18'h0;
        mem_ok   = 1'b0;
        mem_data = 8'h00;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // model state for the random phase
    logic        m_cv, m_pv;
    logic [15:0] m_ca;
    logic [17:0] m_pa;
    logic        p_mcs, p_cpend, p_ppend;
    logic [18:0] p_maddr;
    logic [15:0] p_caddr;
    logic [17:0] p_paddr;
    logic [18:0] pmap;
    logic        e_ok, legal;
    int          cwait, pwait, cmax, pmax;

    initial begin
        int n;
        int cs_cnt;
        int grants;
        int pcm_grant_idx;
        logic prev_cs;

        tbl[0]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00000, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b1, 19'h00123, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b1, 19'h00123, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b0, 8'h5A, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 16'h0123, 1'b0, 18'h0,     1'b1, 8'h5A, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 16'h0123, 1'b1, 18'h00010, 1'b1, 8'h33, 1'b0, 19'h00123, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 16'h0123, 1'b1, 18'h00010, 1'b1, 8'h33, 1'b1, 19'h10010, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 16'h0123, 1'b1, 18'h00010, 1'b1, 8'h33, 1'b1, 19'h10010, 1'b1, 8'h5A, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 16'h0123, 1'b1, 18'h00010, 1'b1, 8'h33, 1'b0, 19'h10010, 1'b1, 8'h5A, 1'b1, 8'h33};
        tbl[13] = '{1'b1, 16'h0123, 1'b1, 18'h00010, 1'b1, 8'h33, 1'b0, 19'h10010, 1'b1, 8'h5A, 1'b1, 8'h33};

        // ---- reset values and basic cached accesses
        do_reset();
        cpu_cs = 1'b1;
        #1;
        chk("rst_mem_cs", mem_cs, 1'b0);
        chk("rst_mem_addr", mem_addr, 19'h0);
        chk("rst_cpu_ok", cpu_ok, 1'b0);
        chk("rst_pcm_data", pcm_data, 8'h00);
        cpu_cs = 1'b0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cpu_cs   = tbl[i].cpu_cs;
            cpu_addr = tbl[i].cpu_addr;
            pcm_cs   = tbl[i].pcm_cs;
            pcm_addr = tbl[i].pcm_addr;
            mem_ok   = tbl[i].mem_ok;
            mem_data = tbl[i].mem_data;
            #1;
            chk($sformatf("tbl%0d_mem_cs", i), mem_cs, tbl[i].e_mem_cs);
            chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_mem_addr);
            chk($sformatf("tbl%0d_cpu_ok", i), cpu_ok, tbl[i].e_cpu_ok);
            chk($sformatf("tbl%0d_cpu_data", i), cpu_data, tbl[i].e_cpu_data);
            chk($sformatf("tbl%0d_pcm_ok", i), pcm_ok, tbl[i].e_pcm_ok);
            chk($sformatf("tbl%0d_pcm_data", i), pcm_data, tbl[i].e_pcm_data);
            next_cycle();
        end

        // ---- CPU address moves during WAIT
        do_reset();
        cpu_cs   = 1'b1;
        cpu_addr = 16'h0100;
        next_cycle();
        next_cycle();
        cpu_addr = 16'h0200;
        mem_ok   = 1'b1;
        mem_data = fmem(19'h00100);
        #1;
        chk("mv_wait_addr", mem_addr, 19'h00100);
        chk("mv_wait_ok", cpu_ok, 1'b0);
        next_cycle();
        mem_ok = 1'b0;
        #1;
        chk("mv_done_ok", cpu_ok, 1'b0);
        chk("mv_done_cs", mem_cs, 1'b0);
        cpu_addr = 16'h0100;
        #1;
        chk("mv_tag_old_ok", cpu_ok, 1'b1);
        chk("mv_tag_old_data", cpu_data, fmem(19'h00100));
        cpu_addr = 16'h0200;
        next_cycle();
        #1;
        chk("mv_idle_cs", mem_cs, 1'b0);
        next_cycle();
        mem_ok   = 1'b1;
        mem_data = fmem(19'h00200);
        #1;
        chk("mv_new_cs", mem_cs, 1'b1);
        chk("mv_new_addr", mem_addr, 19'h00200);
        chk("mv_new_ok0", cpu_ok, 1'b0);
        next_cycle();
        #1;
        chk("mv_new_ok1", cpu_ok, 1'b0);
        next_cycle();
        #1;
        chk("mv_new_ok2", cpu_ok, 1'b1);
        chk("mv_new_data", cpu_data, fmem(19'h00200));

        // ---- reset pulsed during WAIT
        pcm_cs   = 1'b1;
        pcm_addr = 18'h00234;
        mem_ok   = 1'b1;
        mem_data = fmem(19'h10234);
        n = 0;
        #1;
        while (!pcm_ok && n < 10) begin
            next_cycle();
            #1;
            n++;
        end
        chk("rs_pcm_fill", pcm_ok, 1'b1);
        cpu_addr = 16'h0345;
        mem_ok   = 1'b0;
        n = 0;
        #1;
        while (!mem_cs && n < 10) begin
            next_cycle();
            #1;
            n++;
        end
        chk("rs_grant", mem_cs, 1'b1);
        next_cycle();
        #1;
        chk("rs_pre_pcm_ok", pcm_ok, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rs_mem_cs", mem_cs, 1'b0);
        chk("rs_cpu_ok", cpu_ok, 1'b0);
        chk("rs_pcm_ok", pcm_ok, 1'b0);
        pcm_cs = 1'b0;
        next_cycle();
        rst_n    = 1'b1;
        mem_ok   = 1'b1;
        mem_data = fmem(19'h00345);
        #1;
        n = 0;
        while (!cpu_ok && n < 10) begin
            if (mem_cs) chk("rs_reissue_addr", mem_addr, 19'h00345);
            next_cycle();
            #1;
            n++;
        end
        chk("rs_reissue_lat", n, 3);
        chk("rs_reissue_data", cpu_data, fmem(19'h00345));

        // ---- stale mem_ok must not capture in ISSUE
        do_reset();
        cpu_cs   = 1'b1;
        cpu_addr = 16'h0777;
        mem_ok   = 1'b1;
        mem_data = fmem(19'h00777);
        next_cycle();
        mem_data = 8'hEE;
        #1;
        chk("st_issue_cs", mem_cs, 1'b1);
        chk("st_issue_ok", cpu_ok, 1'b0);
        next_cycle();
        mem_data = fmem(19'h00777);
        #1;
        chk("st_wait_ok", cpu_ok, 1'b0);
        next_cycle();
        #1;
        chk("st_done_ok", cpu_ok, 1'b1);
        chk("st_done_data", cpu_data, fmem(19'h00777));

        // ---- anti-starvation: mem_ok arrives on the 3rd cycle of mem_cs
        do_reset();
        cpu_cs   = 1'b1;
        cpu_addr = 16'h0400;
        pcm_cs   = 1'b1;
        pcm_addr = 18'h00100;
        cs_cnt   = 0;
        grants   = 0;
        pcm_grant_idx = -1;
        prev_cs  = 1'b0;
        for (int c = 0; c < 80 && pcm_grant_idx < 0; c++) begin
            cs_cnt   = mem_cs ? cs_cnt + 1 : 0;
            mem_ok   = (cs_cnt >= 3);
            mem_data = fmem(mem_addr);
            #1;
            if (mem_cs && !prev_cs) begin
                if (mem_addr >= OFF) pcm_grant_idx = grants;
                else if (grants == 0) chk("sv_first_is_cpu", mem_addr, 19'h00400);
                grants++;
            end
            prev_cs = mem_cs;
            next_cycle();
            if (cpu_ok) cpu_addr = cpu_addr + 16'd1;
        end
        // each CPU transfer: grant + ISSUE + 2 WAIT + DONE cycles
        chk("sv_pcm_grant_idx", pcm_grant_idx, (MAXWAIT + 5 - 1) / 5);

        // ---- randomized traffic against a transaction-level cache model
        do_reset();
        m_cv = 1'b0; m_pv = 1'b0; m_ca = '0; m_pa = '0;
        p_mcs = 1'b0; p_maddr = '0; p_cpend = 1'b0; p_ppend = 1'b0;
        p_caddr = '0; p_paddr = '0;
        cwait = 0; pwait = 0; cmax = 0; pmax = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) cpu_cs = ~cpu_cs;
            if ($urandom_range(0, 15) == 0) pcm_cs = ~pcm_cs;
            if ($urandom_range(0, 9) == 0) cpu_addr = 16'h0040 + 16'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) pcm_addr = 18'h20000 + 18'($urandom_range(0, 5));
            mem_ok   = ($urandom_range(0, 2) != 0);
            mem_data = fmem(mem_addr);
            #1;
            if (p_mcs && !mem_cs) begin
                if (p_maddr >= OFF) begin
                    m_pv = 1'b1;
                    m_pa = 18'(p_maddr - OFF);
                end else begin
                    m_cv = 1'b1;
                    m_ca = p_maddr[15:0];
                end
            end
            if (mem_cs && !p_mcs) begin
                pmap  = {1'b0, p_paddr} + OFF;
                legal = (p_cpend && mem_addr == {3'b000, p_caddr}) ||
                        (p_ppend && mem_addr == pmap);
                chk("rnd_grant_legal", legal, 1'b1);
            end
            if (mem_cs && p_mcs) chk("rnd_addr_stable", mem_addr, p_maddr);
            e_ok = cpu_cs && m_cv && (m_ca == cpu_addr);
            chk("rnd_cpu_ok", cpu_ok, e_ok);
            if (cpu_ok) chk("rnd_cpu_data", cpu_data, fmem({3'b000, cpu_addr}));
            e_ok = pcm_cs && m_pv && (m_pa == pcm_addr);
            chk("rnd_pcm_ok", pcm_ok, e_ok);
            if (pcm_ok) chk("rnd_pcm_data", pcm_data, fmem({1'b0, pcm_addr} + OFF));
            cwait = (cpu_cs && !cpu_ok && cpu_addr == p_caddr) ? cwait + 1 : 0;
            pwait = (pcm_cs && !pcm_ok && pcm_addr == p_paddr) ? pwait + 1 : 0;
            if (cwait > cmax) cmax = cwait;
            if (pwait > pmax) pmax = pwait;
            p_cpend = cpu_cs && !(m_cv && m_ca == cpu_addr);
            p_ppend = pcm_cs && !(m_pv && m_pa == pcm_addr);
            p_caddr = cpu_addr;
            p_paddr = pcm_addr;
            p_mcs   = mem_cs;
            p_maddr = mem_addr;
            next_cycle();
        end
        chk("rnd_cpu_live", cmax <= 60, 1'b1);
        chk("rnd_pcm_live", pmax <= 60, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
